// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared FSM encoding and default sizes for the register dumper
package reg_dump_pkg;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
endpackage

// File: rtl/reg_dump_if.sv
// reg_dump_if: control, reg_file read port and output stream of the dumper
interface reg_dump_if #(
  parameter int ADDR_W = reg_dump_pkg::ADDR_W_DEF,
  parameter int DATA_W = reg_dump_pkg::DATA_W_DEF
);
  logic start, busy, done, out_valid, out_ready;
  logic [ADDR_W-1:0] ra, out_addr;
  logic [DATA_W-1:0] rd, out_data;
  modport master (input start, rd, out_ready, output busy, done, ra, out_data, out_addr, out_valid);
  modport slave (output start, rd, out_ready, input busy, done, ra, out_data, out_addr, out_valid);
endinterface

// File: rtl/reg_dump.sv
// reg_dump: walks x0..x(NUM_REGS-1) through the reg_file read port and streams each word out
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic rst,
  reg_dump_if.master bus
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, busy_q, busy_d, done_q, done_d, last;
  assign last = idx_q == ADDR_W'(NUM_REGS - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    addr_d = addr_q;
    data_d = data_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = READ;
        idx_d = '0;
      end
      READ: begin
        state_d = SEND;
        data_d = bus.rd;
        addr_d = idx_q;
      end
      SEND: if (bus.out_ready) begin
        state_d = last ? DONE : READ;
        idx_d = last ? idx_q : idx_q + 1'b1;
      end
      DONE: state_d = IDLE;
    endcase
    // outputs are registered alongside the state they describe
    valid_d = state_d == SEND;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      data_q <= data_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.ra = idx_q;
  assign bus.out_addr = addr_q;
  assign bus.out_data = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed table plus multi-cycle dump sequences against a behavioural reg_file
module tb_reg_dump;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mem [32];
  reg_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();
  reg_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.rd = mem[bus.ra];
  always #5 clk = ~clk;

  typedef struct {
    logic r, s, y;
    logic busy, valid, done;
    logic [4:0] ra, addr;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_of(input int k);
    return k == 7 ? 32'hDEADBEEF : 32'(k * 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dump(input int mode, input int restart_at, input int rst_at);
    int w, cyc;
    bit fin, ab, stl;
    logic [4:0] pa;
    logic [31:0] pd;
    w = 0; cyc = 0; fin = 0; ab = 0; stl = 0; pa = '0; pd = '0;
    bus.start = 1'b1;
    bus.out_ready = mode == 0;
    while (!fin && cyc < 400) begin
      tick();
      cyc++;
      bus.start = 1'b0;
      if (cyc == 2 && mode == 0) chk("first_valid", 32'(bus.out_valid), 32'd1);
      if (stl && bus.out_valid) begin
        chk("stall_addr", 32'(bus.out_addr), 32'(pa));
        chk("stall_data", bus.out_data, pd);
      end
      if (bus.done) begin
        chk("done_words", 32'(w), 32'd32);
        if (mode == 0) chk("done_cycle", 32'(cyc), 32'd65);
        fin = 1;
      end else if (bus.out_valid && w == rst_at) begin
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        repeat (4) begin
          tick();
          chk("abort_quiet", 32'({bus.out_valid, bus.done, bus.busy}), 32'd0);
        end
        fin = 1;
        ab = 1;
      end else begin
        bus.out_ready = mode == 0 || cyc % 4 == 0;
        if (bus.out_valid && w == restart_at) bus.start = 1'b1;
        if (bus.out_valid && bus.out_ready) begin
          chk("word_addr", 32'(bus.out_addr), 32'(w));
          chk("word_data", bus.out_data, exp_of(w));
          if (w == 7) chk("x7", bus.out_data, 32'hDEADBEEF);
          w++;
        end
        stl = bus.out_valid && !bus.out_ready;
        pa = bus.out_addr;
        pd = bus.out_data;
      end
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dump_timeout: got no done after %0d cycles, required done", cyc);
    end else if (!ab) begin
      repeat (4) begin
        tick();
        chk("post_idle", 32'({bus.busy, bus.done, bus.out_valid}), 32'd0);
      end
    end
  endtask

  initial begin
    int d1, d2, nd;
    for (int k = 0; k < 32; k++) mem[k] = 32'(k * 3);
    mem[7] = 32'hDEADBEEF;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 32'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 32'd3};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 32'd3};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 5'd1, 32'd3};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 5'd2, 32'd6};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    chk("reset_state", 32'({bus.busy, bus.done, bus.out_valid}), 32'd0);
    chk("reset_addr", 32'(bus.out_addr), 32'd0);
    chk("reset_data", bus.out_data, 32'd0);
    chk("reset_ra", 32'(bus.ra), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].r;
      bus.start = tbl[i].s;
      bus.out_ready = tbl[i].y;
      tick();
      chk($sformatf("row%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].valid));
      chk($sformatf("row%0d_done", i), 32'(bus.done), 32'(tbl[i].done));
      chk($sformatf("row%0d_ra", i), 32'(bus.ra), 32'(tbl[i].ra));
      chk($sformatf("row%0d_addr", i), 32'(bus.out_addr), 32'(tbl[i].addr));
      chk($sformatf("row%0d_data", i), bus.out_data, tbl[i].data);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    dump(0, -1, -1);
    dump(1, -1, -1);
    dump(0, 5, -1);
    dump(0, -1, 10);
    dump(0, -1, -1);
    d1 = 0; d2 = 0; nd = 0;
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      tick();
      if (bus.done) begin
        nd++;
        if (nd == 1) d1 = c;
        if (nd == 2) d2 = c;
      end
      if (d1 != 0 && c == d1 + 1) chk("hold_idle_gap", 32'(bus.busy), 32'd0);
      if (d1 != 0 && c == d1 + 2) chk("hold_restart", 32'(bus.busy), 32'd1);
    end
    chk("hold_done_count", 32'(nd), 32'd2);
    chk("hold_done1", 32'(d1), 32'd65);
    chk("hold_done2", 32'(d2), 32'd131);
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
